// File: rtl/smpwm_if.sv
// Sample input and PWM output bundle for the sign-magnitude H-bridge stage.
// The upstream side (or a bench) uses the master modport; smpwm uses slave.
interface smpwm_if;
  logic [15:0] in_mag;        // sample magnitude
  logic        in_sign;       // sample sign, 1 = negative
  logic        in_valid;      // one-cycle strobe qualifying in_mag/in_sign
  logic        pwm_p;         // positive-leg drive
  logic        pwm_n;         // negative-leg drive
  logic        period_start;  // one-cycle strobe, doubles as sample request
  logic        sat;           // active duty was clamped
  logic        overrun;       // shadow overwritten before it was used

  modport master (
    output in_mag, in_sign, in_valid,
    input  pwm_p, pwm_n, period_start, sat, overrun
  );

  modport slave (
    input  in_mag, in_sign, in_valid,
    output pwm_p, pwm_n, period_start, sat, overrun
  );
endinterface

// File: rtl/smpwm.sv
// Sign-magnitude H-bridge PWM stage.
// A free-running CNT_W-bit counter defines the PWM period. Incoming samples are
// clamped and parked in a shadow register, and only become the active duty on
// the last count of a period. When the active polarity flips between two
// nonzero duties, both legs are held low for DEAD clocks at the start of the
// new period, which eats into the pulse rather than delaying it.
module smpwm #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEAD  = 4
) (
  input  logic   clk,
  input  logic   rst,
  smpwm_if.slave bus
);

  localparam int unsigned      PERIOD_MAX = (2 ** CNT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PERIOD_MAX);
  localparam logic [15:0]      MAG_MAX    = 16'(PERIOD_MAX);
  localparam bit               DEAD_EN    = (DEAD != 0);
  // The down-counter runs DEAD-1 .. 0, so the legs stay low for exactly DEAD clocks.
  localparam logic [CNT_W-1:0] DEAD_LOAD  = DEAD_EN ? CNT_W'(DEAD - 1) : '0;

  typedef enum logic {
    ST_RUN,
    ST_DEAD
  } state_e;

  // One buffered sample: clamped duty, sign (with -0 folded to +0), clamp flag.
  typedef struct packed {
    logic [CNT_W-1:0] duty;
    logic             sign;
    logic             sat;
  } sample_t;

  // Period counter and strobes
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             overrun_q, overrun_d;

  // Double buffer
  sample_t          shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  sample_t          active_q, active_d;

  // Dead-time FSM and leg drive
  state_e           state_q;
  logic [CNT_W-1:0] dead_cnt_q;
  logic             pwm_p_q, pwm_n_q;

  logic             boundary;
  logic             reversal;
  logic             leg_on;
  sample_t          in_sample;

  assign boundary = (cnt_q == CNT_MAX);

  // Clamp the incoming magnitude and fold negative zero onto positive zero.
  always_comb begin
    in_sample.sat  = (bus.in_mag > MAG_MAX);
    in_sample.duty = in_sample.sat ? CNT_MAX : bus.in_mag[CNT_W-1:0];
    in_sample.sign = bus.in_sign && (bus.in_mag != 16'd0);
  end

  // Next-state for the counter, strobes and the shadow/active double buffer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d          = cnt_q + CNT_W'(1);
    period_start_d = (cnt_q == '0);
    shadow_d       = shadow_q;
    shadow_full_d  = shadow_full_q;
    active_d       = active_q;
    overrun_d      = 1'b0;

    if (boundary) begin
      // A sample arriving on the boundary bypasses the shadow and discards any
      // parked sample without flagging an overrun.
      if (bus.in_valid) begin
        active_d      = in_sample;
        shadow_full_d = 1'b0;
      end else if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end
    end else if (bus.in_valid) begin
      shadow_d      = in_sample;
      shadow_full_d = 1'b1;
      overrun_d     = shadow_full_q;
    end
  end

  // A reversal needs a real pulse on both sides of the boundary; 0 -> x is not one.
  always_comb begin
    reversal = DEAD_EN && boundary
            && (active_d.sign != active_q.sign)
            && (active_d.duty != '0)
            && (active_q.duty != '0);
    leg_on   = (cnt_q < active_q.duty) && (state_q == ST_RUN);
  end

  // Counter, strobes and sample buffers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      overrun_q      <= 1'b0;
      shadow_q       <= '0;
      shadow_full_q  <= 1'b0;
      active_q       <= '0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      overrun_q      <= overrun_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
      active_q       <= active_d;
    end
  end

  // Dead-time FSM with registered leg outputs (one clock behind cnt).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      dead_cnt_q <= '0;
      pwm_p_q    <= 1'b0;
      pwm_n_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (reversal) begin
            state_q    <= ST_DEAD;
            dead_cnt_q <= DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (reversal) begin
            dead_cnt_q <= DEAD_LOAD;
          end else if (dead_cnt_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            dead_cnt_q <= dead_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q    <= ST_RUN;
          dead_cnt_q <= '0;
        end
      endcase

      // Both legs come from the single active sign, so they can never overlap.
      pwm_p_q <= leg_on && !active_q.sign;
      pwm_n_q <= leg_on &&  active_q.sign;
    end
  end

  assign bus.pwm_p        = pwm_p_q;
  assign bus.pwm_n        = pwm_n_q;
  assign bus.period_start = period_start_q;
  assign bus.sat          = active_q.sat;
  assign bus.overrun      = overrun_q;

  // Shoot-through guard on the bridge legs.
  a_legs_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(pwm_p_q && pwm_n_q));

endmodule

// File: tb/tb_smpwm.sv
// Bench for smpwm with CNT_W=4 (period 16), DEAD=2.
// A per-period reference model predicts, at each boundary, the high time of
// each leg for the coming period (clamped duty, minus DEAD on a reversal); a
// monitor integrates the legs over each period and compares. Directed tasks
// cover the listed scenarios, then a randomized run exercises the mix.
module tb_smpwm;
  localparam int CNT_W = 4;
  localparam int DEAD  = 2;
  localparam int PER   = 16;
  localparam int MAXD  = PER - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  smpwm_if bus ();

  smpwm #(.CNT_W(CNT_W), .DEAD(DEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (what cnt is after the latest edge, buffers, expectations)
  int m_cnt    = 0;
  bit in_reset = 1'b1;
  bit sh_full  = 1'b0;
  int sh_duty  = 0;
  bit sh_sign  = 1'b0;
  bit sh_sat   = 1'b0;
  int act_duty = 0;
  bit act_sign = 1'b0;
  bit act_sat  = 1'b0;
  int cur_p = 0, cur_n = 0, prev_p = 0, prev_n = 0;
  bit exp_ovr  = 1'b0;

  // Monitor state
  int acc_p = 0, acc_n = 0, last_p = 0, last_n = 0;
  bit win_valid = 1'b0;
  int c_out;

  // Model scratch
  int nd, hi;
  bit ns, nsat, rev;

  // Reference model: advances once per clock from the spec's period rules.
  always @(posedge clk) begin
    if (rst) begin
      in_reset = 1'b1;
      m_cnt    = 0;
      sh_full  = 1'b0;
      act_duty = 0;
      act_sign = 1'b0;
      act_sat  = 1'b0;
      cur_p = 0; cur_n = 0; prev_p = 0; prev_n = 0;
      exp_ovr  = 1'b0;
    end else begin
      in_reset = 1'b0;
      exp_ovr  = 1'b0;
      if (m_cnt == PER - 1) begin
        if (bus.in_valid) begin
          nd   = (bus.in_mag > MAXD) ? MAXD : int'(bus.in_mag);
          ns   = bus.in_sign && (bus.in_mag != 0);
          nsat = (bus.in_mag > MAXD);
        end else if (sh_full) begin
          nd = sh_duty; ns = sh_sign; nsat = sh_sat;
        end else begin
          nd = act_duty; ns = act_sign; nsat = act_sat;
        end
        sh_full = 1'b0;
        rev = (DEAD > 0) && (ns != act_sign) && (nd != 0) && (act_duty != 0);
        hi  = rev ? ((nd > DEAD) ? nd - DEAD : 0) : nd;
        prev_p = cur_p; prev_n = cur_n;
        cur_p  = ns ? 0 : hi;
        cur_n  = ns ? hi : 0;
        act_duty = nd; act_sign = ns; act_sat = nsat;
      end else if (bus.in_valid) begin
        exp_ovr = sh_full;
        sh_duty = (bus.in_mag > MAXD) ? MAXD : int'(bus.in_mag);
        sh_sign = bus.in_sign && (bus.in_mag != 0);
        sh_sat  = (bus.in_mag > MAXD);
        sh_full = 1'b1;
      end
      m_cnt = (m_cnt + 1) % PER;
    end
  end

  // Monitor: outputs seen at a falling edge reflect the count before the last rising edge.
  always @(negedge clk) begin
    if (in_reset) begin
      acc_p = 0; acc_n = 0; win_valid = 1'b0;
      checks++;
      if ({bus.pwm_p, bus.pwm_n, bus.period_start, bus.sat, bus.overrun} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 00000",
                 {bus.pwm_p, bus.pwm_n, bus.period_start, bus.sat, bus.overrun});
      end
    end else begin
      c_out = (m_cnt + PER - 1) % PER;
      checks++;
      if (bus.period_start !== (c_out == 0)) begin
        errors++;
        $display("FAIL period_start at count %0d: got %b want %b", c_out, bus.period_start, c_out == 0);
      end
      checks++;
      if (bus.pwm_p && bus.pwm_n) begin
        errors++;
        $display("FAIL legs_exclusive at %0t: got pwm_p=1 pwm_n=1 want not both", $time);
      end
      checks++;
      if (bus.sat !== act_sat) begin
        errors++;
        $display("FAIL sat at %0t: got %b want %b", $time, bus.sat, act_sat);
      end
      checks++;
      if (bus.overrun !== exp_ovr) begin
        errors++;
        $display("FAIL overrun at %0t: got %b want %b", $time, bus.overrun, exp_ovr);
      end
      if (c_out == 0) begin
        acc_p = 0; acc_n = 0; win_valid = 1'b1;
      end
      acc_p += int'(bus.pwm_p);
      acc_n += int'(bus.pwm_n);
      if (c_out == PER - 1 && win_valid) begin
        checks++;
        if (acc_p != prev_p) begin
          errors++;
          $display("FAIL period_high_p at %0t: got %0d want %0d", $time, acc_p, prev_p);
        end
        checks++;
        if (acc_n != prev_n) begin
          errors++;
          $display("FAIL period_high_n at %0t: got %0d want %0d", $time, acc_n, prev_n);
        end
        last_p = acc_p;
        last_n = acc_n;
      end
    end
  end

  // Wait at falling edges until the model count reaches v (bounded).
  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != v && n < 64);
    if (m_cnt != v) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: got count %0d want %0d within 64 clocks", m_cnt, v);
    end
  endtask

  // Return just after the monitor has closed the next period.
  task automatic next_close();
    wait_cnt(0);
    @(negedge clk);
  endtask

  task automatic send(input int mag, input bit sign);
    bus.in_mag   = 16'(mag);
    bus.in_sign  = sign;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pwm_p, bus.pwm_n, bus.period_start, bus.sat, bus.overrun} !== 5'b0) begin
      errors++;
      $display("FAIL test_reset: got %b want 00000",
               {bus.pwm_p, bus.pwm_n, bus.period_start, bus.sat, bus.overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int ps = 0;
    next_close();
    next_close();
    repeat (32) begin
      @(negedge clk);
      ps += int'(bus.period_start);
    end
    checks++;
    if (ps != 2) begin errors++; $display("FAIL idle_period_start: got %0d pulses want 2", ps); end
    checks++;
    if (last_p != 0 || last_n != 0) begin
      errors++; $display("FAIL idle_legs: got p=%0d n=%0d want 0 0", last_p, last_n);
    end
    checks++;
    if (bus.sat !== 1'b0) begin errors++; $display("FAIL idle_sat: got %b want 0", bus.sat); end
  endtask

  task automatic test_positive();
    wait_cnt(6);
    send(5, 1'b0);
    next_close();
    next_close();
    checks++;
    if (last_p != 5 || last_n != 0) begin
      errors++; $display("FAIL positive_5: got p=%0d n=%0d want 5 0", last_p, last_n);
    end
    next_close();
    checks++;
    if (last_p != 5 || last_n != 0) begin
      errors++; $display("FAIL positive_repeat: got p=%0d n=%0d want 5 0", last_p, last_n);
    end
  endtask

  task automatic test_reversal();
    wait_cnt(6);
    send(7, 1'b1);
    next_close();
    next_close();
    checks++;
    if (last_p != 0 || last_n != 5) begin
      errors++; $display("FAIL reversal_to_neg: got p=%0d n=%0d want 0 5", last_p, last_n);
    end
    next_close();
    checks++;
    if (last_n != 7) begin errors++; $display("FAIL neg_7: got n=%0d want 7", last_n); end
    wait_cnt(6);
    send(5, 1'b0);
    next_close();
    next_close();
    checks++;
    if (last_p != 3 || last_n != 0) begin
      errors++; $display("FAIL reversal_to_pos: got p=%0d n=%0d want 3 0", last_p, last_n);
    end
    next_close();
    wait_cnt(6);
    send(1, 1'b1);
    next_close();
    next_close();
    checks++;
    if (last_p != 0 || last_n != 0) begin
      errors++; $display("FAIL short_reversal: got p=%0d n=%0d want 0 0", last_p, last_n);
    end
    next_close();
    checks++;
    if (last_n != 1) begin errors++; $display("FAIL neg_1: got n=%0d want 1", last_n); end
  endtask

  task automatic test_saturation();
    wait_cnt(6);
    send(3, 1'b0);
    next_close();
    next_close();
    checks++;
    if (last_p != 1) begin errors++; $display("FAIL reversal_to_pos3: got p=%0d want 1", last_p); end
    wait_cnt(6);
    send(300, 1'b0);
    next_close();
    next_close();
    checks++;
    if (last_p != 15) begin errors++; $display("FAIL sat_high_time: got p=%0d want 15", last_p); end
    checks++;
    if (bus.sat !== 1'b1) begin errors++; $display("FAIL sat_set: got %b want 1", bus.sat); end
    wait_cnt(6);
    send(3, 1'b0);
    next_close();
    next_close();
    checks++;
    if (last_p != 3) begin errors++; $display("FAIL unsat_high_time: got p=%0d want 3", last_p); end
    checks++;
    if (bus.sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b want 0", bus.sat); end
  endtask

  task automatic test_back_to_back();
    wait_cnt(3);
    send(4, 1'b0);
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL first_write_overrun: got %b want 0", bus.overrun); end
    wait_cnt(8);
    send(9, 1'b0);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL second_write_overrun: got %b want 1", bus.overrun); end
    next_close();
    next_close();
    checks++;
    if (last_p != 9) begin errors++; $display("FAIL last_write_wins: got p=%0d want 9", last_p); end
    wait_cnt(5);
    send(4, 1'b0);
    wait_cnt(15);
    send(6, 1'b0);
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL boundary_overrun: got %b want 0", bus.overrun); end
    next_close();
    checks++;
    if (last_p != 6) begin errors++; $display("FAIL boundary_bypass: got p=%0d want 6", last_p); end
  endtask

  task automatic test_reset_mid();
    wait_cnt(6);
    send(7, 1'b1);
    next_close();
    next_close();
    wait_cnt(3);
    checks++;
    if (bus.pwm_n !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse: got pwm_n=%b want 1", bus.pwm_n); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pwm_p !== 1'b0 || bus.pwm_n !== 1'b0) begin
      errors++; $display("FAIL reset_mid_legs: got p=%b n=%b want 0 0", bus.pwm_p, bus.pwm_n);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.period_start !== 1'b1) begin
      errors++; $display("FAIL reset_mid_count: got period_start=%b want 1", bus.period_start);
    end
    wait_cnt(6);
    send(5, 1'b1);
    next_close();
    next_close();
    checks++;
    if (last_n != 5) begin errors++; $display("FAIL post_reset_no_dead: got n=%0d want 5", last_n); end
  endtask

  task automatic test_random();
    int r, mag;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(1, 12)) @(negedge clk);
      r = int'($urandom_range(0, 9));
      if (r < 6)      mag = int'($urandom_range(0, 17));
      else if (r < 8) mag = 0;
      else            mag = int'($urandom_range(0, 65535));
      send(mag, 1'($urandom_range(0, 1)));
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_mag   = '0;
    bus.in_sign  = 1'b0;
    bus.in_valid = 1'b0;
    test_reset();
    test_idle();
    test_positive();
    test_reversal();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
